// File: rtl/spi_ram_ctrl_pkg.sv
// Shared command encodings, FSM states and grant indices for the SPI RAM controller.
// Also holds the two-way round-robin pick function.
package spi_ram_ctrl_pkg;

   typedef enum logic [1:0] {
      CMD_WADDR = 2'b00,
      CMD_WDATA = 2'b01,
      CMD_RADDR = 2'b10,
      CMD_RDATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RDATA  = 2'b10
   } state_e;

   localparam logic GNT_SPI  = 1'b0;
   localparam logic GNT_HOST = 1'b1;

   // Returns the index of the winning requester; on a tie the one not granted last wins.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      if (req == 2'b11)
         return ~last;
      else if (req[GNT_SPI])
         return GNT_SPI;
      else
         return GNT_HOST;
   endfunction

endpackage

// File: rtl/spi_ram_ctrl_arb.sv
// Two-requester round-robin arbiter: bit 0 = SPI, bit 1 = host.
// last_gnt only moves when the grant is actually consumed (advance).
module rr_arb2
   import spi_ram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic last_gnt_reg;
   logic winner;

   assign winner = rr_pick(req, last_gnt_reg);

   always_comb begin
      gnt = 2'b00;
      if (|req)
         gnt[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt_reg <= GNT_HOST;
      else if (advance && |req)
         last_gnt_reg <= winner;
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command words into RAM accesses and shares the single-port RAM with a host
// req/gnt port; one access in flight at a time, IDLE -> ACCESS -> (RDATA) -> IDLE.
module spi_ram_ctrl
   import spi_ram_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter bit AUTO_INC  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           rx_data,
   input  logic                 rx_valid,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [7:0]           host_wdata,
   output logic                 host_gnt,
   output logic [7:0]           host_rdata,
   output logic                 host_rvalid,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   input  logic [7:0]           ram_rdata,
   output logic                 spi_ovf
);

   localparam logic [ADDR_SIZE-1:0] ADDR_INC = AUTO_INC ? ADDR_SIZE'(1) : '0;

   state_e               state_reg;
   logic [ADDR_SIZE-1:0] wr_addr_reg;
   logic [ADDR_SIZE-1:0] rd_addr_reg;
   logic                 spi_pend_reg;
   logic                 pend_we_reg;
   logic [ADDR_SIZE-1:0] pend_addr_reg;
   logic [7:0]           pend_wdata_reg;
   logic                 acc_host_reg;

   cmd_e                 cmd;
   logic [ADDR_SIZE-1:0] rx_addr;
   logic [1:0]           req;
   logic [1:0]           gnt;
   logic                 advance;

   assign cmd     = cmd_e'(rx_data[9:8]);
   assign rx_addr = rx_data[ADDR_SIZE-1:0];
   assign req     = {host_req, spi_pend_reg};
   assign advance = (state_reg == ST_IDLE);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (advance),
      .gnt     (gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         wr_addr_reg    <= '0;
         rd_addr_reg    <= '0;
         spi_pend_reg   <= 1'b0;
         pend_we_reg    <= 1'b0;
         pend_addr_reg  <= '0;
         pend_wdata_reg <= '0;
         acc_host_reg   <= 1'b0;
         tx_data        <= '0;
         tx_valid       <= 1'b0;
         host_gnt       <= 1'b0;
         host_rdata     <= '0;
         host_rvalid    <= 1'b0;
         ram_en         <= 1'b0;
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         spi_ovf        <= 1'b0;
      end else begin
         host_gnt    <= 1'b0;
         host_rvalid <= 1'b0;
         ram_en      <= 1'b0;

         // SPI decode runs in every FSM state; only the single pending slot couples it to the FSM.
         if (rx_valid) begin
            tx_valid <= 1'b0;
            unique case (cmd)
               CMD_WADDR: wr_addr_reg <= rx_addr;
               CMD_RADDR: rd_addr_reg <= rx_addr;
               CMD_WDATA: begin
                  if (spi_pend_reg) begin
                     spi_ovf <= 1'b1;
                  end else begin
                     spi_pend_reg   <= 1'b1;
                     pend_we_reg    <= 1'b1;
                     pend_addr_reg  <= wr_addr_reg;
                     pend_wdata_reg <= rx_data[7:0];
                     wr_addr_reg    <= wr_addr_reg + ADDR_INC;
                  end
               end
               CMD_RDATA: begin
                  if (spi_pend_reg) begin
                     spi_ovf <= 1'b1;
                  end else begin
                     spi_pend_reg  <= 1'b1;
                     pend_we_reg   <= 1'b0;
                     pend_addr_reg <= rd_addr_reg;
                     rd_addr_reg   <= rd_addr_reg + ADDR_INC;
                  end
               end
            endcase
         end

         case (state_reg)
            ST_IDLE: begin
               if (|req) begin
                  state_reg <= ST_ACCESS;
                  ram_en    <= 1'b1;
                  if (gnt[GNT_HOST]) begin
                     acc_host_reg <= 1'b1;
                     host_gnt     <= 1'b1;
                     ram_we       <= host_we;
                     ram_addr     <= host_addr;
                     ram_wdata    <= host_wdata;
                  end else begin
                     acc_host_reg <= 1'b0;
                     spi_pend_reg <= 1'b0;
                     ram_we       <= pend_we_reg;
                     ram_addr     <= pend_addr_reg;
                     ram_wdata    <= pend_wdata_reg;
                  end
               end
            end
            ST_ACCESS: begin
               state_reg <= ram_we ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
               state_reg <= ST_IDLE;
               if (acc_host_reg) begin
                  host_rdata  <= ram_rdata;
                  host_rvalid <= 1'b1;
               end else begin
                  tx_data  <= ram_rdata;
                  tx_valid <= 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
